// File: rtl/trigger_pkg.sv
// trigger_pkg: shared encodings for the oscilloscope trigger unit.
//   state_e : FSM state encodings, also driven out on the status port
//   mode_e  : acquisition modes (auto / normal / single)
//   edge_e  : trigger edge selection
package trigger_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_e;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

  // Encoding 3 has no mode of its own and behaves as normal.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_AUTO;
      2'd2:    return MODE_SINGLE;
      default: return MODE_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/trigger_compare.sv
// trigger_compare: hysteresis thresholds and per-sample arm/level decision.
//   i_data     : current ADC sample
//   i_level    : trigger threshold
//   i_hyst     : hysteresis band (8 bits)
//   i_edge_sel : 0 = rising, 1 = falling
//   o_arm      : sample lies beyond the hysteresis band (re-arms the trigger)
//   o_meet     : sample has reached the trigger level for the selected edge
module trigger_compare
  import trigger_pkg::*;
#(
  parameter int unsigned DW = 12
) (
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_level,
  input  logic [7:0]    i_hyst,
  input  logic          i_edge_sel,
  output logic          o_arm,
  output logic          o_meet
);

  logic [DW:0]   w_hyst_ext;
  logic [DW:0]   w_hi_sum;
  logic [DW:0]   w_lo_diff;
  logic [DW-1:0] w_hi_th;
  logic [DW-1:0] w_lo_th;

  // One extra bit catches overflow of level+hyst and borrow of level-hyst,
  // so both thresholds clamp instead of wrapping.
  assign w_hyst_ext = {{(DW-7){1'b0}}, i_hyst};
  assign w_hi_sum   = {1'b0, i_level} + w_hyst_ext;
  assign w_lo_diff  = {1'b0, i_level} - w_hyst_ext;
  assign w_hi_th    = w_hi_sum[DW]  ? '1 : w_hi_sum[DW-1:0];
  assign w_lo_th    = w_lo_diff[DW] ? '0 : w_lo_diff[DW-1:0];

  always_comb begin
    o_arm  = 1'b0;
    o_meet = 1'b0;
    if (edge_e'(i_edge_sel) == EDGE_FALL) begin
      o_arm  = (i_data > w_hi_th);
      o_meet = (i_data <= i_level);
    end else begin
      o_arm  = (i_data < w_lo_th);
      o_meet = (i_data >= i_level);
    end
  end

endmodule

// File: rtl/trigger_unit.sv
// trigger_unit: edge trigger controller for a pre/post-trigger capture buffer.
//   clock, reset        : system clock, asynchronous active-high reset
//   sampleEn            : valid-sample strobe; all counters step only on it
//   data, level, hyst   : sample, threshold, hysteresis band
//   edgeSel, mode       : edge select; auto/normal/single (3 = normal)
//   run, arm            : level enable; re-arm request in single mode
//   hold                : freeze request to the capture buffer (high only in HOLD)
//   trigPulse, autoFlag : one-cycle trigger pulse; last trigger was a timeout
//   state               : current FSM state
module trigger_unit
  import trigger_pkg::*;
#(
  parameter int unsigned DW           = 12,
  parameter int unsigned PRE_SAMPLES  = 320,
  parameter int unsigned POST_SAMPLES = 320,
  parameter int unsigned HOLDOFF      = 64,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sampleEn,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] level,
  input  logic [7:0]    hyst,
  input  logic          edgeSel,
  input  logic [1:0]    mode,
  input  logic          run,
  input  logic          arm,
  output logic          hold,
  output logic          trigPulse,
  output logic          autoFlag,
  output logic [2:0]    state
);

  state_e      r_state;
  mode_e       r_mode;
  logic [31:0] r_cnt;
  logic        r_armed;
  logic        r_hold;
  logic        r_trig;
  logic        r_auto;

  logic        w_arm;
  logic        w_meet;
  logic        w_fire;

  trigger_compare #(.DW(DW)) u_cmp (
    .i_data     (data),
    .i_level    (level),
    .i_hyst     (hyst),
    .i_edge_sel (edgeSel),
    .o_arm      (w_arm),
    .o_meet     (w_meet)
  );

  // Only an arm recorded on an earlier sample qualifies, so a single sample
  // can never both arm and fire.
  assign w_fire = r_armed && w_meet;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_AUTO;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_hold  <= 1'b0;
      r_trig  <= 1'b0;
      r_auto  <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      if (!run) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_armed <= 1'b0;
        r_hold  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_PRE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_mode  <= decode_mode(mode);
          end
          S_PRE: begin
            if (sampleEn) begin
              if (r_cnt == PRE_SAMPLES - 1) begin
                r_state <= S_WAIT_TRIG;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          S_WAIT_TRIG: begin
            if (sampleEn) begin
              if (w_fire) begin
                r_state <= S_POST;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_trig  <= 1'b1;
                r_auto  <= 1'b0;
              end else if (r_mode == MODE_AUTO && r_cnt == AUTO_TIMEOUT - 1) begin
                r_state <= S_POST;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_trig  <= 1'b1;
                r_auto  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 32'd1;
                if (w_arm) r_armed <= 1'b1;
              end
            end
          end
          S_POST: begin
            if (sampleEn) begin
              if (r_cnt == POST_SAMPLES - 1) begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
                r_hold  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          S_HOLD: begin
            // Single mode waits for arm regardless of sampleEn; the other
            // modes count out the holdoff period.
            if (r_mode == MODE_SINGLE) begin
              if (arm) begin
                r_state <= S_PRE;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_hold  <= 1'b0;
                r_mode  <= decode_mode(mode);
              end
            end else if (sampleEn) begin
              if (r_cnt == HOLDOFF - 1) begin
                r_state <= S_PRE;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_hold  <= 1'b0;
                r_mode  <= decode_mode(mode);
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_hold  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hold      = r_hold;
  assign trigPulse = r_trig;
  assign autoFlag  = r_auto;
  assign state     = r_state;

endmodule
